// File: rtl/valid_ready_fifo.sv
// First-word-fall-through elastic buffer for valid/ready streams with occupancy
// reporting and synchronous flush. ready_in depends only on the registered count.
module valid_ready_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] data_out,
   input  logic             ready_out,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_nxt;
   logic             push;
   logic             pop;

   assign ready_in  = (count_q != CW'(DEPTH));
   assign valid_out = (count_q != '0);
   assign push      = valid_in & ready_in;
   assign pop       = valid_out & ready_out;
   assign count     = count_q;

   // Empty FIFO drives zero rather than stale storage; no bypass of a same-cycle push.
   assign data_out  = valid_out ? mem[rd_ptr] : '0;

   always_comb begin
      count_nxt = count_q;
      case ({push, pop})
         2'b10:   count_nxt = count_q + CW'(1);
         2'b01:   count_nxt = count_q - CW'(1);
         default: count_nxt = count_q;
      endcase
   end

   // Control state: rst over flush over push/pop; pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_nxt;
      end
   end

   // Payload storage carries no reset.
   always_ff @(posedge clk) begin
      if (push && !rst && !flush) mem[wr_ptr] <= data_in;
   end

endmodule
